tsn_tx_pri_sched: RTL and testbench
===================================

// Module: tsn_tx_pri_sched
// PURPOSE
// - Per-port strict-priority transmit scheduler downstream of the Qav credit shaper.
// - Takes the shaper's eligible-queue mask, picks one priority queue, and emits the scheduling
//   result the shaper consumes (i_scheduing_rst / i_scheduing_rst_vld).
// - Holds the grant for one whole frame on the MAC TX AXIS bus, then enforces an inter-frame gap
//   before the next decision.
// PARAMETERS
// - PORT_FIFO_PRI_NUM  8     number of priority queues; index 7 is the highest priority.
// - IFG_CYCLES         3     idle cycles in GAP after the last beat; legal range 1-255.
// - WDOG_CYCLES        4096  watchdog limit in XMIT; only used with TX_SCHED_WATCHDOG_EN.
// PORTS
// - i_clk                 in   1      250 MHz clock; the only clock.
// - i_rst                 in   1      synchronous, active-high reset.
// - i_sched_en            in   1      scheduler enable; sampled in IDLE only.
// - i_queue               in   N      eligible mask from the shaper (o_queue).
// - i_queue_vld           in   1      mask valid pulse (o_queue_vld).
// - i_fifoc_empty         in   N      per-priority CROSSBAR FIFO empty flags.
// - i_mac_tx_axis_valid   in   1      MAC TX beat valid.
// - i_mac_tx_axis_last    in   1      MAC TX last beat of the frame.
// - o_scheduing_rst       out  N      one-hot granted queue.
// - o_scheduing_rst_vld   out  1      1-cycle grant pulse.
// - o_sel_pri             out  3      binary index of the granted queue.
// - o_busy                out  1      high in ARB, GRANT, XMIT and GAP.
// - o_tx_frame_cnt        out  16     count of completed frames; saturates at 16'hFFFF.
// - o_wdog_abort          out  1      1-cycle watchdog abort pulse.
// BEHAVIOUR
// - Reset: state=IDLE; every output 0; internal mask and counters 0.
// - IDLE
//   - Condition: i_queue_vld && i_sched_en.
//   - Action: latch elig = i_queue & ~i_fifoc_empty.
//   - elig!=0 -> ARB; elig==0 -> stay IDLE, no pulse.
// - ARB: grant = one-hot of the highest set bit of elig (strict priority) -> GRANT.
// - GRANT
//   - Drive o_scheduing_rst=grant, o_sel_pri=index, o_scheduing_rst_vld=1 for exactly 1 cycle.
//   - Latency: 2 cycles from the i_queue_vld sample edge to the vld pulse. Next state XMIT.
// - XMIT
//   - o_scheduing_rst stays stable; beats are counted on i_mac_tx_axis_valid.
//   - valid && last -> GAP; o_tx_frame_cnt +1, saturating.
//   - A single-beat frame (valid && last on the first XMIT cycle) is legal.
// - GAP
//   - On entry: clear o_scheduing_rst and o_sel_pri; load the gap counter with IFG_CYCLES-1.
//   - Count down to 0 -> IDLE.
// - i_queue_vld outside IDLE is ignored; it is not queued.
// - A new decision therefore needs a fresh shaper pulse after GAP.
// - i_sched_en low mid-frame: the current frame and its GAP complete; then the block stays IDLE.
// - i_fifoc_empty changes after the IDLE latch do not alter the grant.
// - i_rst asserted in any state returns to reset values on the next edge.
//   - No pulse is emitted; o_tx_frame_cnt is cleared.
// CONFIGURATION
// - Macro TX_SCHED_WATCHDOG_EN
//   - Defined
//     - A 16-bit counter runs in XMIT and clears on XMIT entry.
//     - Reaching WDOG_CYCLES without valid && last -> GAP.
//     - o_wdog_abort pulses 1 cycle; o_tx_frame_cnt is not incremented.
//   - Not defined
//     - No counter; XMIT waits indefinitely for last.
//     - o_wdog_abort is tied to 0.
// TESTING
// - T1 priority pick
//   - Stimulus: i_queue=8'h24, i_fifoc_empty=8'hDB, vld pulse at cycle t.
//   - Response: at t+2, o_scheduing_rst=8'h20, o_sel_pri=5, vld high for 1 cycle.
// - T2 empty mask
//   - Stimulus: i_queue=8'h04, i_fifoc_empty=8'hFF.
//   - Response: no vld pulse; o_busy stays 0.
// - T3 ignored pulse
//   - Stimulus: 5-beat frame; second i_queue_vld at beat 2.
//   - Response: ignored; one grant only; o_tx_frame_cnt=1.
// - T4 gap timing
//   - Stimulus: last at cycle L, IFG_CYCLES=3.
//   - Response: o_scheduing_rst=0 at L+1; IDLE at L+4; a vld at L+4 is granted at L+6.
// - T5 watchdog (TX_SCHED_WATCHDOG_EN, WDOG_CYCLES=16)
//   - Stimulus: grant, then no last.
//   - Response: o_wdog_abort at XMIT cycle 16; frame count unchanged.
// - T6 reset mid-frame
//   - Stimulus: i_rst in XMIT beat 3.
//   - Response: all outputs 0 next cycle; a new vld is granted normally.

Source files
------------

// File: rtl/tsn_tx_pri_sched.sv
// Per-port strict-priority TX scheduler: picks one eligible queue, holds it for a frame, then applies an IFG.
// Optional watchdog on stuck frames is enabled by defining TX_SCHED_WATCHDOG_EN.
module tsn_tx_pri_sched #(
  parameter int PORT_FIFO_PRI_NUM = 8,
  parameter int IFG_CYCLES        = 3
`ifdef TX_SCHED_WATCHDOG_EN
  ,
  parameter int WDOG_CYCLES       = 4096
`endif
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_sched_en,
  input  logic [PORT_FIFO_PRI_NUM-1:0] i_queue,
  input  logic                         i_queue_vld,
  input  logic [PORT_FIFO_PRI_NUM-1:0] i_fifoc_empty,
  input  logic                         i_mac_tx_axis_valid,
  input  logic                         i_mac_tx_axis_last,
  output logic [PORT_FIFO_PRI_NUM-1:0] o_scheduing_rst,
  output logic                         o_scheduing_rst_vld,
  output logic [2:0]                   o_sel_pri,
  output logic                         o_busy,
  output logic [15:0]                  o_tx_frame_cnt,
  output logic                         o_wdog_abort
);

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    GRANT,
    XMIT,
    GAP
  } state_t;

  state_t                       state;
  logic [PORT_FIFO_PRI_NUM-1:0] elig;
  logic [7:0]                   gap_cnt;
  logic [PORT_FIFO_PRI_NUM-1:0] pick_onehot;
  logic [2:0]                   pick_idx;
  logic [PORT_FIFO_PRI_NUM-1:0] elig_now;
  logic                         frame_done;

`ifdef TX_SCHED_WATCHDOG_EN
  localparam logic [15:0] WDOG_LIMIT = 16'(WDOG_CYCLES - 1);
  logic [15:0] wdog_cnt;
`endif

  assign elig_now   = i_queue & ~i_fifoc_empty;
  assign frame_done = i_mac_tx_axis_valid && i_mac_tx_axis_last;

  // Highest set bit wins; later iterations overwrite lower-priority hits.
  always_comb begin
    pick_onehot = '0;
    pick_idx    = '0;
    for (int i = 0; i < PORT_FIFO_PRI_NUM; i++) begin
      if (elig[i]) begin
        pick_onehot    = '0;
        pick_onehot[i] = 1'b1;
        pick_idx       = 3'(i);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state               <= IDLE;
      elig                <= '0;
      gap_cnt             <= '0;
      o_scheduing_rst     <= '0;
      o_scheduing_rst_vld <= 1'b0;
      o_sel_pri           <= '0;
      o_busy              <= 1'b0;
      o_tx_frame_cnt      <= '0;
      o_wdog_abort        <= 1'b0;
`ifdef TX_SCHED_WATCHDOG_EN
      wdog_cnt            <= '0;
`endif
    end else begin
      o_scheduing_rst_vld <= 1'b0;
      o_wdog_abort        <= 1'b0;
      case (state)
        IDLE: begin
          if (i_queue_vld && i_sched_en) begin
            elig <= elig_now;
            if (elig_now != '0) begin
              state  <= ARB;
              o_busy <= 1'b1;
            end
          end
        end
        ARB: begin
          o_scheduing_rst     <= pick_onehot;
          o_sel_pri           <= pick_idx;
          o_scheduing_rst_vld <= 1'b1;
          state               <= GRANT;
        end
        GRANT: begin
          state <= XMIT;
`ifdef TX_SCHED_WATCHDOG_EN
          wdog_cnt <= '0;
`endif
        end
        XMIT: begin
          if (frame_done) begin
            state           <= GAP;
            o_scheduing_rst <= '0;
            o_sel_pri       <= '0;
            gap_cnt         <= 8'(IFG_CYCLES - 1);
            if (o_tx_frame_cnt != 16'hFFFF) begin
              o_tx_frame_cnt <= o_tx_frame_cnt + 16'd1;
            end
          end
`ifdef TX_SCHED_WATCHDOG_EN
          // Abort a frame that never delivers its last beat; it is not counted.
          else if (wdog_cnt == WDOG_LIMIT) begin
            state           <= GAP;
            o_scheduing_rst <= '0;
            o_sel_pri       <= '0;
            gap_cnt         <= 8'(IFG_CYCLES - 1);
            o_wdog_abort    <= 1'b1;
          end else begin
            wdog_cnt <= wdog_cnt + 16'd1;
          end
`endif
        end
        GAP: begin
          if (gap_cnt == 8'd0) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tsn_tx_pri_sched.sv
// Randomized self-checking bench for tsn_tx_pri_sched against a transaction-level priority/timing model.
module tb_tsn_tx_pri_sched;

  localparam int N   = 8;
  localparam int IFG = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         sched_en;
  logic [N-1:0] queue;
  logic         queue_vld;
  logic [N-1:0] fifoc_empty;
  logic         axis_valid;
  logic         axis_last;
  logic [N-1:0] sched_rst;
  logic         sched_rst_vld;
  logic [2:0]   sel_pri;
  logic         busy;
  logic [15:0]  frame_cnt;
  logic         wdog_abort;

  int checks = 0;
  int errors = 0;
  int exp_frames = 0;

  always #2 clk = ~clk;

  tsn_tx_pri_sched #(
    .PORT_FIFO_PRI_NUM(N),
    .IFG_CYCLES(IFG)
`ifdef TX_SCHED_WATCHDOG_EN
    ,
    .WDOG_CYCLES(16)
`endif
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_sched_en(sched_en),
    .i_queue(queue),
    .i_queue_vld(queue_vld),
    .i_fifoc_empty(fifoc_empty),
    .i_mac_tx_axis_valid(axis_valid),
    .i_mac_tx_axis_last(axis_last),
    .o_scheduing_rst(sched_rst),
    .o_scheduing_rst_vld(sched_rst_vld),
    .o_sel_pri(sel_pri),
    .o_busy(busy),
    .o_tx_frame_cnt(frame_cnt),
    .o_wdog_abort(wdog_abort)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strict priority: index of the highest eligible queue, -1 if none.
  function automatic int refPick(input logic [N-1:0] m);
    for (int i = N - 1; i >= 0; i--) begin
      if (m[i]) return i;
    end
    return -1;
  endfunction

  task automatic checkQuiet(input string tag);
    checkOutput({tag, "_rst"}, 32'(sched_rst), 32'd0);
    checkOutput({tag, "_sel"}, 32'(sel_pri), 32'd0);
    checkOutput({tag, "_vld"}, 32'(sched_rst_vld), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_abort"}, 32'(wdog_abort), 32'd0);
  endtask

  // One scheduling attempt from IDLE: shaper pulse, then a frame of 'beats' beats if granted.
  task automatic applyStimulus(input logic [N-1:0] q, input logic [N-1:0] e, input int beats,
                               input bit spurious, input bit drop_en, input int rst_beat);
    int idx;
    int idle_n;
    logic [N-1:0] exp_oh;
    bit grant_exp;
    grant_exp = sched_en;
    idx = refPick(q & ~e);
    if (idx < 0) grant_exp = 1'b0;
    exp_oh = (idx >= 0) ? (N'(1) << idx) : '0;
    queue = q;
    fifoc_empty = e;
    queue_vld = 1'b1;
    tick();
    queue_vld = 1'b0;
    queue = N'($urandom);
    fifoc_empty = N'($urandom);
    if (!grant_exp) begin
      for (int k = 0; k < 3; k++) begin
        checkOutput("nogrant_vld", 32'(sched_rst_vld), 32'd0);
        checkOutput("nogrant_busy", 32'(busy), 32'd0);
        tick();
      end
      return;
    end
    checkOutput("arb_busy", 32'(busy), 32'd1);
    checkOutput("arb_vld", 32'(sched_rst_vld), 32'd0);
    tick();
    checkOutput("grant_vld", 32'(sched_rst_vld), 32'd1);
    checkOutput("grant_onehot", 32'(sched_rst), 32'(exp_oh));
    checkOutput("grant_sel", 32'(sel_pri), 32'(idx));
    tick();
    checkOutput("pulse_width", 32'(sched_rst_vld), 32'd0);
    for (int b = 1; b <= beats; b++) begin
      idle_n = $urandom_range(0, 2);
      for (int k = 0; k < idle_n; k++) begin
        axis_valid = 1'b0;
        axis_last = 1'($urandom);
        tick();
        checkOutput("hold_rst", 32'(sched_rst), 32'(exp_oh));
        checkOutput("no_repulse", 32'(sched_rst_vld), 32'd0);
      end
      axis_valid = 1'b1;
      axis_last = (b == beats);
      if (spurious && b == 2) begin
        queue_vld = 1'b1;
        queue = '1;
        fifoc_empty = '0;
      end
      if (drop_en && b == 1) sched_en = 1'b0;
      if (rst_beat == b) rst = 1'b1;
      tick();
      axis_valid = 1'b0;
      axis_last = 1'b0;
      queue_vld = 1'b0;
      if (rst_beat == b) begin
        rst = 1'b0;
        exp_frames = 0;
        checkQuiet("midrst");
        checkOutput("midrst_cnt", 32'(frame_cnt), 32'd0);
        return;
      end
      if (b < beats) begin
        checkOutput("beat_hold", 32'(sched_rst), 32'(exp_oh));
        checkOutput("beat_sel", 32'(sel_pri), 32'(idx));
        checkOutput("beat_busy", 32'(busy), 32'd1);
        checkOutput("beat_vld", 32'(sched_rst_vld), 32'd0);
      end
    end
    if (exp_frames < 65535) exp_frames++;
    checkOutput("gap_rst_clr", 32'(sched_rst), 32'd0);
    checkOutput("gap_sel_clr", 32'(sel_pri), 32'd0);
    checkOutput("gap_busy", 32'(busy), 32'd1);
    checkOutput("frame_cnt", 32'(frame_cnt), 32'(exp_frames));
    checkOutput("gap_abort", 32'(wdog_abort), 32'd0);
    for (int g = 1; g < IFG; g++) begin
      tick();
      checkOutput("gap_hold_busy", 32'(busy), 32'd1);
    end
    tick();
    checkOutput("gap_done_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int wait_n;
    logic [N-1:0] rq;
    logic [N-1:0] re;
    rst = 1'b1;
    sched_en = 1'b1;
    queue = '0;
    queue_vld = 1'b0;
    fifoc_empty = '0;
    axis_valid = 1'b0;
    axis_last = 1'b0;
    tick();
    tick();
    checkQuiet("reset");
    checkOutput("reset_cnt", 32'(frame_cnt), 32'd0);
    rst = 1'b0;
    tick();

    $display("[TB] T1 priority pick");
    applyStimulus(8'h24, 8'hDB, 3, 1'b0, 1'b0, 0);
    $display("[TB] T2 empty mask");
    applyStimulus(8'h04, 8'hFF, 2, 1'b0, 1'b0, 0);
    $display("[TB] T3 ignored pulse");
    applyStimulus(8'h13, 8'h02, 5, 1'b1, 1'b0, 0);
    $display("[TB] single-beat frames at both priority extremes");
    applyStimulus(8'h01, 8'h00, 1, 1'b0, 1'b0, 0);
    applyStimulus(8'hFF, 8'h00, 1, 1'b0, 1'b0, 0);
    $display("[TB] T6 reset mid-frame");
    applyStimulus(8'h81, 8'h00, 5, 1'b0, 1'b0, 3);
    applyStimulus(8'h42, 8'h40, 2, 1'b0, 1'b0, 0);
    $display("[TB] enable dropped mid-frame");
    applyStimulus(8'h0C, 8'h00, 4, 1'b0, 1'b1, 0);
    applyStimulus(8'hFF, 8'h00, 2, 1'b0, 1'b0, 0);
    sched_en = 1'b1;

    $display("[TB] randomized transactions");
    for (int n = 0; n < 60; n++) begin
      rq = N'($urandom);
      re = ($urandom_range(0, 3) == 0) ? '1 : N'($urandom);
      applyStimulus(rq, re, $urandom_range(1, 6), 1'($urandom), 1'b0, 0);
    end

`ifdef TX_SCHED_WATCHDOG_EN
    $display("[TB] T5 watchdog");
    queue = 8'h02;
    fifoc_empty = '0;
    queue_vld = 1'b1;
    tick();
    queue_vld = 1'b0;
    tick();
    checkOutput("wd_grant", 32'(sched_rst_vld), 32'd1);
    wait_n = 0;
    while (wdog_abort !== 1'b1 && wait_n < 40) begin
      tick();
      wait_n++;
    end
    checkOutput("wd_latency", 32'(wait_n), 32'd17);
    checkOutput("wd_rst_clr", 32'(sched_rst), 32'd0);
    checkOutput("wd_cnt_same", 32'(frame_cnt), 32'(exp_frames));
    tick();
    checkOutput("wd_pulse_width", 32'(wdog_abort), 32'd0);
    for (int g = 0; g < IFG; g++) tick();
    checkOutput("wd_idle", 32'(busy), 32'd0);
`else
    wait_n = 0;
    checkOutput("wd_tied_low", 32'(wdog_abort), 32'(wait_n));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
